// File: rtl/debug_step_controller.sv
// debug_step_controller: host-command sequencer that steps the 5-stage MIPS pipeline and streams a state dump.
// Build option: define DEBUG_CYCLE_COUNT_EN to add the 32-bit step counter and the CYCLES dump item.
module debug_step_controller #(
    parameter int NB              = 32,
    parameter int N_REGS          = 32,
    parameter int TAM_DATA_MEMORY = 16,
    parameter int MAX_RUN_CYCLES  = 1024
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cmd_valid,
    input  logic [7:0]    i_cmd,
    output logic          o_cmd_ready,
    output logic          o_tx_valid,
    output logic [7:0]    o_tx_data,
    input  logic          i_tx_ready,
    output logic          o_step,
    output logic          o_pipeline_reset,
    output logic [4:0]    o_debug_reg_num,
    output logic [NB-1:0] o_debug_address,
    input  logic [NB-1:0] i_mips_pc,
    input  logic [NB-1:0] i_mips_register_data,
    input  logic [NB-1:0] i_mips_data_memory,
    input  logic          i_halt,
    output logic          o_busy
);

    localparam int BYTES_PER_WORD = NB / 8;
`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int N_HDR = 2;
`else
    localparam int N_HDR = 1;
`endif
    localparam int N_ITEMS = N_HDR + N_REGS + TAM_DATA_MEMORY;
    localparam int ITEM_W  = $clog2(N_ITEMS + 1);
    localparam int BYTE_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int RUN_W   = (MAX_RUN_CYCLES > 1) ? $clog2(MAX_RUN_CYCLES) : 1;

    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] CMD_RST  = 8'h52;
    localparam logic [7:0] BYTE_NAK = 8'h3F;
    localparam logic [7:0] BYTE_ACK = 8'h4B;

    typedef enum logic [3:0] {
        S_IDLE,
        S_STEP,
        S_RUN,
        S_RST,
        S_REPLY,
        S_SEL,
        S_WAIT,
        S_LATCH,
        S_SEND
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [ITEM_W-1:0]   item;
    logic [ITEM_W-1:0]   reg_off;
    logic [ITEM_W-1:0]   mem_off;
    logic [BYTE_W-1:0]   byte_idx;
    logic [RUN_W-1:0]    run_cnt;
    logic                rst_cnt;
    logic [NB-1:0]       shift_q;
    logic [NB-1:0]       latch_word;
    logic [7:0]          reply_q;
    logic                cmd_fire;
    logic                is_reg;
    logic                is_mem;
    logic                last_item;
    logic                last_byte;
    logic                run_last;

    assign o_cmd_ready = (state == S_IDLE);
    assign o_busy      = (state != S_IDLE);
    assign cmd_fire    = i_cmd_valid && (state == S_IDLE);
    assign o_tx_valid  = (state == S_SEND) || (state == S_REPLY);
    assign o_tx_data   = (state == S_REPLY) ? reply_q : shift_q[NB-1 -: 8];

    // Dump item decode: PC, [CYCLES], registers, then data-memory words.
    assign reg_off   = item - ITEM_W'(N_HDR);
    assign mem_off   = item - ITEM_W'(N_HDR + N_REGS);
    assign is_reg    = (item >= ITEM_W'(N_HDR)) && (item < ITEM_W'(N_HDR + N_REGS));
    assign is_mem    = (item >= ITEM_W'(N_HDR + N_REGS));
    assign last_item = (item == ITEM_W'(N_ITEMS - 1));
    assign last_byte = (byte_idx == BYTE_W'(BYTES_PER_WORD - 1));
    assign run_last  = (run_cnt == RUN_W'(MAX_RUN_CYCLES - 1));

`ifdef DEBUG_CYCLE_COUNT_EN
    logic        is_cyc;
    logic [31:0] cycle_cnt;

    assign is_cyc = (item == ITEM_W'(1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cycle_cnt <= '0;
        end else if (cmd_fire && (i_cmd == CMD_RST)) begin
            cycle_cnt <= '0;
        end else if (o_step && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        latch_word = i_mips_pc;
        if (is_reg) begin
            latch_word = i_mips_register_data;
        end else if (is_mem) begin
            latch_word = i_mips_data_memory;
        end
`ifdef DEBUG_CYCLE_COUNT_EN
        else if (is_cyc) begin
            latch_word = NB'(cycle_cnt);
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no path leaves it unassigned and infers a latch.
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (i_cmd)
                        CMD_STEP: state_nx = S_STEP;
                        CMD_RUN:  state_nx = i_halt ? S_SEL : S_RUN;
                        CMD_DUMP: state_nx = S_SEL;
                        CMD_RST:  state_nx = S_RST;
                        default:  state_nx = S_REPLY;
                    endcase
                end
            end
            S_STEP:  state_nx = S_SEL;
            S_RUN:   if (i_halt || run_last) state_nx = S_SEL;
            S_RST:   if (rst_cnt) state_nx = S_REPLY;
            S_REPLY: if (i_tx_ready) state_nx = S_IDLE;
            S_SEL:   state_nx = S_WAIT;
            S_WAIT:  state_nx = S_LATCH;
            S_LATCH: state_nx = S_SEND;
            S_SEND: begin
                if (i_tx_ready && last_byte) begin
                    state_nx = last_item ? S_IDLE : S_SEL;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Step and pipeline-reset strobes are registered copies of the upcoming state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_step           <= 1'b0;
            o_pipeline_reset <= 1'b0;
            o_debug_reg_num  <= '0;
            o_debug_address  <= '0;
            item             <= '0;
            byte_idx         <= '0;
            run_cnt          <= '0;
            rst_cnt          <= 1'b0;
            shift_q          <= '0;
            reply_q          <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            o_step           <= (state_nx == S_STEP) || (state_nx == S_RUN);
            o_pipeline_reset <= (state_nx == S_RST);
            case (state)
                S_IDLE: begin
                    item    <= '0;
                    run_cnt <= '0;
                    rst_cnt <= 1'b0;
                    if (cmd_fire) begin
                        reply_q <= (i_cmd == CMD_RST) ? BYTE_ACK : BYTE_NAK;
                    end
                end
                S_RUN: run_cnt <= run_cnt + RUN_W'(1);
                S_RST: rst_cnt <= 1'b1;
                S_SEL: begin
                    if (is_reg) begin
                        o_debug_reg_num <= 5'(reg_off);
                    end
                    if (is_mem) begin
                        o_debug_address <= NB'(mem_off) << 2;
                    end
                end
                S_LATCH: begin
                    byte_idx <= '0;
                    shift_q  <= latch_word;
                end
                S_SEND: begin
                    if (i_tx_ready) begin
                        shift_q  <= {shift_q[NB-9:0], 8'h00};
                        byte_idx <= byte_idx + BYTE_W'(1);
                        if (last_byte) begin
                            item <= item + ITEM_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_step_controller.sv
// Self-checking bench for debug_step_controller with a behavioural pipeline stand-in and a byte scoreboard.
`timescale 1ns/1ps
module tb_debug_step_controller;

    localparam int NB      = 32;
    localparam int N_REGS  = 32;
    localparam int TAM     = 16;
    localparam int MAX_RUN = 1024;
`ifdef DEBUG_CYCLE_COUNT_EN
    localparam bit CYC_EN     = 1'b1;
    localparam int DUMP_BYTES = 4 * (2 + N_REGS + TAM);
`else
    localparam bit CYC_EN     = 1'b0;
    localparam int DUMP_BYTES = 4 * (1 + N_REGS + TAM);
`endif

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic [7:0]    i_cmd = 8'h00;
    logic          o_cmd_ready;
    logic          o_tx_valid;
    logic [7:0]    o_tx_data;
    logic          i_tx_ready;
    logic          o_step;
    logic          o_pipeline_reset;
    logic [4:0]    o_debug_reg_num;
    logic [NB-1:0] o_debug_address;
    logic [NB-1:0] i_mips_pc;
    logic [NB-1:0] i_mips_register_data;
    logic [NB-1:0] i_mips_data_memory;
    logic          i_halt;
    logic          o_busy;

    debug_step_controller #(
        .NB(NB), .N_REGS(N_REGS), .TAM_DATA_MEMORY(TAM), .MAX_RUN_CYCLES(MAX_RUN)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready),
        .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
        .o_step(o_step), .o_pipeline_reset(o_pipeline_reset),
        .o_debug_reg_num(o_debug_reg_num), .o_debug_address(o_debug_address),
        .i_mips_pc(i_mips_pc), .i_mips_register_data(i_mips_register_data),
        .i_mips_data_memory(i_mips_data_memory), .i_halt(i_halt), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int         checks = 0;
    int         fails  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] base_reg(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : (32'hA500_0000 | (32'(r) << 8) | 32'(r));
    endfunction

    // R4 becomes R5+R3 once the ADD (fetched at PC 0x08) has retired, i.e. from PC 0x1C on.
    function automatic logic [31:0] reg_val(input logic [4:0] r, input bit add_done);
        if (r == 5'd4 && add_done) return base_reg(5'd5) + base_reg(5'd3);
        return base_reg(r);
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Pipeline stand-in: PC advances 4 per step until it reaches halt_pc.
    logic [31:0] pipe_pc;
    logic [31:0] halt_pc = 32'hFFFF_FFF0;
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset)               pipe_pc <= 32'd0;
        else if (o_pipeline_reset) pipe_pc <= 32'd0;
        else if (o_step && !i_halt) pipe_pc <= pipe_pc + 32'd4;
    end
    assign i_halt               = (pipe_pc == halt_pc);
    assign i_mips_pc            = pipe_pc;
    assign i_mips_register_data = reg_val(o_debug_reg_num, pipe_pc >= 32'd28);
    assign i_mips_data_memory   = mem_val(o_debug_address);

    logic toggle_mode = 1'b0;
    logic tog = 1'b0;
    always @(posedge i_clk) tog <= ~tog;
    assign i_tx_ready = toggle_mode ? tog : 1'b1;

    int         step_cycles = 0;
    int         prst_cycles = 0;
    int         rx_bytes = 0;
    logic       last_stall = 1'b0;
    logic [7:0] last_data = 8'h00;

    always @(negedge i_clk) begin
        if (o_step) step_cycles++;
        if (o_pipeline_reset) prst_cycles++;
        if (last_stall && o_tx_valid) check("tx_hold", 32'(o_tx_data), 32'(last_data));
        last_stall = o_tx_valid && !i_tx_ready;
        last_data  = o_tx_data;
        if (o_tx_valid && i_tx_ready) begin
            rx_bytes++;
            if (exp_q.size() == 0) check("tx_extra", 32'(o_tx_valid), 32'd0);
            else check("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    endtask

    task automatic expect_dump(input logic [31:0] pc, input logic [31:0] cyc);
        push_word(pc);
        if (CYC_EN) push_word(cyc);
        for (int r = 0; r < N_REGS; r++) push_word(reg_val(5'(r), pc >= 32'd28));
        for (int m = 0; m < TAM; m++) push_word(mem_val(32'(m * 4)));
    endtask

    task automatic send_cmd(input logic [7:0] b, input string tag);
        @(posedge i_clk);
        #1 i_cmd_valid = 1'b1;
        i_cmd = b;
        @(posedge i_clk);
        #1 i_cmd_valid = 1'b0;
        check({tag, "_accept"}, 32'(o_busy), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < 5000) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    task automatic do_cmd(input logic [7:0] b, input int exp_steps, input string tag);
        int s0 = step_cycles;
        send_cmd(b, tag);
        wait_idle(tag);
        @(negedge i_clk);
        check({tag, "_steps"}, 32'(step_cycles - s0), 32'(exp_steps));
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] exp_pc;
    logic [31:0] exp_cyc;
    int          rb;
    int          p0;

    initial begin
        #2 i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check("rst_tx_data", 32'(o_tx_data), 32'd0);
        check("rst_step", 32'(o_step), 32'd0);
        check("rst_pipe_reset", 32'(o_pipeline_reset), 32'd0);
        check("rst_reg_num", 32'(o_debug_reg_num), 32'd0);
        check("rst_address", o_debug_address, 32'd0);
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        exp_pc  = 32'd0;
        exp_cyc = 32'd0;

        rb = rx_bytes;
        expect_dump(exp_pc, exp_cyc);
        do_cmd(8'h44, 0, "dump0");
        check("dump0_len", 32'(rx_bytes - rb), 32'(DUMP_BYTES));

        for (int k = 1; k <= 7; k++) begin
            exp_pc  = exp_pc + 32'd4;
            exp_cyc = exp_cyc + 32'd1;
            expect_dump(exp_pc, exp_cyc);
            do_cmd(8'h53, 1, "step");
        end

        toggle_mode = 1'b1;
        rb = rx_bytes;
        expect_dump(exp_pc, exp_cyc);
        do_cmd(8'h44, 0, "dump_tog");
        check("dump_tog_len", 32'(rx_bytes - rb), 32'(DUMP_BYTES));
        toggle_mode = 1'b0;

        p0 = prst_cycles;
        exp_q.push_back(8'h4B);
        do_cmd(8'h52, 0, "prst");
        check("prst_cycles", 32'(prst_cycles - p0), 32'd2);
        exp_pc  = 32'd0;
        exp_cyc = 32'd0;

        halt_pc = 32'h20;
        exp_pc  = 32'h20;
        exp_cyc = exp_cyc + 32'd9;
        expect_dump(exp_pc, exp_cyc);
        do_cmd(8'h43, 9, "run_halt");

        expect_dump(exp_pc, exp_cyc);
        do_cmd(8'h43, 0, "run_halt_entry");

        exp_q.push_back(8'h4B);
        do_cmd(8'h52, 0, "prst2");
        halt_pc = 32'hFFFF_FFF0;
        exp_pc  = 32'(4 * MAX_RUN);
        exp_cyc = 32'(MAX_RUN);
        expect_dump(exp_pc, exp_cyc);
        do_cmd(8'h43, MAX_RUN, "run_max");

        rb = rx_bytes;
        exp_q.push_back(8'h3F);
        do_cmd(8'h00, 0, "bad_cmd");
        check("bad_cmd_len", 32'(rx_bytes - rb), 32'd1);

        expect_dump(exp_pc, exp_cyc);
        send_cmd(8'h44, "dump_abort");
        repeat (40) @(negedge i_clk);
        check("mid_dump_busy", 32'(o_busy), 32'd1);
        @(posedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        check("abort_tx_valid", 32'(o_tx_valid), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_step", 32'(o_step), 32'd0);
        check("abort_cmd_ready", 32'(o_cmd_ready), 32'd1);
        exp_q.delete();
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        exp_pc  = 32'd0;
        exp_cyc = 32'd0;

        rb = rx_bytes;
        expect_dump(exp_pc, exp_cyc);
        do_cmd(8'h44, 0, "dump_after_reset");
        check("dump_after_reset_len", 32'(rx_bytes - rb), 32'(DUMP_BYTES));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
